ter_poly_op_seq: RTL

- Sequencer that streams two ternary polynomials coefficient-by-coefficient from two read ports.
- Applies one coefficient-wise ternary operation (add, sub, pointwise mul) using the team's existing ternary arithmetic cells, and writes the result polynomial to a write port.
- Sits in the poly_lift path between the coefficient RAMs and the lift/inverse stages.
- Also reports the Hamming weight of the result and flags invalid coefficient encodings.

---
 rtl/ter_poly_op_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ter_poly_op_seq.sv
// Coefficient-wise ternary polynomial operation sequencer (add / sub / pointwise mul).
// Streams a and b from the read ports, writes the result, and reports weight and encoding errors.
module ter_poly_op_seq #(
  parameter int unsigned N  = 701,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic          abort,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [1:0]    a_rdata,
  input  logic [1:0]    b_rdata,
  output logic          r_we,
  output logic [AW-1:0] r_addr,
  output logic [1:0]    r_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] wt
);

  localparam logic [1:0]    OpAdd    = 2'b00;
  localparam logic [1:0]    OpSub    = 2'b01;
  localparam logic [1:0]    OpMul    = 2'b10;
  localparam logic [1:0]    OpRsv    = 2'b11;
  localparam logic [AW-1:0] LastAddr = AW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e     state_q;
  logic [1:0] op_q;

  // Ternary cells on {sign, nonzero} codes; the invalid code 10 is mapped to zero.
  function automatic logic [1:0] tern_clean(input logic [1:0] x);
    return {x[1] & x[0], x[0]};
  endfunction

  function automatic logic [1:0] tern_neg(input logic [1:0] x);
    return {x[0] & ~x[1], x[0]};
  endfunction

  function automatic logic [1:0] tern_mul(input logic [1:0] x, input logic [1:0] y);
    logic nz;
    nz = x[0] & y[0];
    return {nz & (x[1] ^ y[1]), nz};
  endfunction

  // Mod-3 sum: equal nonzero signs wrap to the opposite sign, opposite signs cancel.
  function automatic logic [1:0] tern_add(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] s;
    if (!x[0]) begin
      s = y;
    end else if (!y[0]) begin
      s = x;
    end else if (x[1] == y[1]) begin
      s = tern_neg(x);
    end else begin
      s = 2'b00;
    end
    return s;
  endfunction

  logic [1:0]    a_c;
  logic [1:0]    b_c;
  logic [1:0]    res;
  logic          in_bad;
  logic          kill;
  logic [AW-1:0] wt_inc;

  always_comb begin
    a_c    = tern_clean(a_rdata);
    b_c    = tern_clean(b_rdata);
    in_bad = (a_rdata == 2'b10) | (b_rdata == 2'b10);
    res    = 2'b00;
    case (op_q)
      OpAdd:   res = tern_add(a_c, b_c);
      OpSub:   res = tern_add(a_c, tern_neg(b_c));
      OpMul:   res = tern_mul(a_c, b_c);
      default: res = 2'b00;
    endcase
    kill   = abort & ((state_q == StRun) | (state_q == StDrain));
    wt_inc = {{(AW-1){1'b0}}, r_wdata[0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wt      <= '0;
    end else begin
      done <= 1'b0;

      // Write pipeline runs one cycle behind the reads regardless of state.
      r_we <= rd_en & ~kill;
      if (rd_en && !kill) begin
        r_addr  <= rd_addr;
        r_wdata <= res;
        if (in_bad) begin
          err <= 1'b1;
        end
      end
      if (r_we) begin
        wt <= wt + wt_inc;
      end

      case (state_q)
        StIdle, StFin: begin
          state_q <= StIdle;
          if (start) begin
            if (op != OpRsv) begin
              op_q    <= op;
              err     <= 1'b0;
              wt      <= '0;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= '0;
              state_q <= StRun;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (abort) begin
            rd_en   <= 1'b0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (rd_addr == LastAddr) begin
            rd_en   <= 1'b0;
            state_q <= StDrain;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        StDrain: begin
          busy <= 1'b0;
          if (abort) begin
            state_q <= StIdle;
          end else begin
            done    <= 1'b1;
            state_q <= StFin;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
